fa_32bit_multicycle: RTL and testbench
======================================

# fa_32bit_multicycle

Multi-cycle 32-bit adder, the addition counterpart of the team's 32-bit full subtractor. It produces Sum, carry-out and Z/N/V status flags for the ALU datapath. Operands are captured on a start handshake and added one SLICE_W-bit slice per cycle, LSB slice first, with the carry registered between slices. A one-cycle done pulse marks the result, which stays held until the next completion.

## Interface
- SLICE_W, default 8: bits added per cycle; must divide 32 (legal values 1, 2, 4, 8, 16, 32).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- A  in  32  operand A, captured when start is accepted.
- B  in  32  operand B, captured when start is accepted.
- Cin  in  1  carry-in, captured when start is accepted.
- busy  out  1  high while in ADD or DONE.
- done  out  1  one-cycle pulse; Sum and flags are valid from this cycle on.
- Sum  out  32  A + B + Cin, modulo 2^32.
- Cout  out  1  carry out of bit 31.
- Z  out  1  1 when Sum == 0.
- N  out  1  equals Sum[31].
- V  out  1  signed overflow: (A[31] == B[31]) && (Sum[31] != A[31]).

## Operation
- NSLICE = 32 / SLICE_W.
- FSM states: IDLE, ADD, DONE.
- IDLE, start = 1:
  - capture A, B and Cin into operand registers;
  - load the carry register with Cin;
  - clear the slice counter and the partial-sum register;
  - go to ADD.
- IDLE, start = 0: stay in IDLE.
- ADD, each cycle:
  - add slice k of A, slice k of B and the carry register;
  - write the slice result into partial-sum bits [k*SLICE_W +: SLICE_W];
  - update the carry register and increment k.
- ADD, slice NSLICE-1:
  - load Sum from the final partial sum;
  - load Cout from the final carry;
  - load Z, N and V from the final 32-bit value (V uses the captured A and B);
  - go to DONE.
- DONE: done = 1 for this cycle only; go to IDLE.
- start is ignored in ADD and DONE. It is not queued. The captured operands are not disturbed.
- Sum, Cout, Z, N and V change only on the edge that enters DONE. At all other times they hold their last value.
- Changing A, B or Cin after capture has no effect on the operation in progress.

## Timing
- Reset values: state IDLE, busy 0, done 0, Sum 0, Cout 0, Z 0, N 0, V 0. Internal counter, carry and partial sum are 0.
- Reset mid-operation: the operation is aborted, no done pulse is issued, and outputs return to their reset values on that edge.
- Latency: with start accepted at edge t, done is high during cycle t+NSLICE+1. SLICE_W = 8 gives 5 cycles.
- busy rises on the cycle after acceptance and falls together with done.
- Throughput: one operation every NSLICE+2 cycles. The earliest next acceptance is the IDLE cycle following DONE.
- start held continuously: a new operation is accepted on each return to IDLE.
- Carry wrap-around: the carry out of slice k feeds slice k+1 on the next cycle. The carry out of the last slice goes to Cout and is never fed back.

## Structure
- Shared package fa_pkg:
  - state enum {IDLE, ADD, DONE};
  - localparam DATA_W = 32;
  - function computing NSLICE from SLICE_W.
- Sub-module fa_slice: combinational SLICE_W-bit adder (a, b, cin -> s, cout), instantiated once and time-multiplexed across slices.
- Top level holds the FSM, slice counter (width clog2(NSLICE), minimum 1), operand registers, carry register, partial-sum register and output registers.
- Elaboration-time check that 32 % SLICE_W == 0.

## Test plan
- A=00000002, B=00000001, Cin=0 -> Sum=00000003, Cout=0, Z=0, N=0, V=0; done exactly 5 cycles after the start edge (SLICE_W=8).
- A=000000FF, B=00000001, Cin=1 -> Sum=00000101, Cout=0: the carry crosses the slice 0 to slice 1 boundary.
- A=FFFFFFFF, B=00000001, Cin=0 -> Sum=00000000, Cout=1, Z=1, N=0, V=0: the carry ripples through all slices.
- A=7FFFFFFF, B=00000001, Cin=0 -> Sum=80000000, N=1, V=1, Cout=0. Then A=80000000, B=80000000, Cin=0 -> Sum=00000000, Cout=1, Z=1, V=1.
- Accept A=00000005, B=00000003, then pulse start with A=12345678, B=1 while busy -> exactly one done, Sum=00000008; the second request is dropped.
- Start A=00000010, B=00000020, assert rst in the second ADD cycle -> no done pulse, all outputs 0. A new start after rst releases completes normally in 5 cycles.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder.
package fa_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  localparam int DATA_W = 32;

  function automatic int nslice(input int slice_w);
    return DATA_W / slice_w;
  endfunction
endpackage

// File: rtl/fa_slice.sv
// Combinational SLICE_W-bit adder; one instance is time-multiplexed over all slices.
module fa_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/fa_32bit_multicycle.sv
// 32-bit adder that processes one SLICE_W-bit slice per cycle, LSB first,
// producing Sum, Cout and Z/N/V with a one-cycle done pulse.
module fa_32bit_multicycle
  import fa_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Sum,
  output logic              Cout,
  output logic              Z,
  output logic              N,
  output logic              V
);
  localparam int NSLICE = nslice(SLICE_W);
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0]      LAST  = CW'(NSLICE - 1);
  localparam logic [DATA_W-1:0]  SMASK = DATA_W'({SLICE_W{1'b1}});

  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_slice_w
      $error("SLICE_W must divide 32");
    end
  endgenerate

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] a_q, b_q, psum;
  logic              carry;

  logic [SLICE_W-1:0] sa, sb, ss;
  logic               sc;
  logic [DATA_W-1:0]  psum_nxt;
  int                 base;

  // Shifts rather than indexed part-selects keep the slice mux in range for every SLICE_W.
  assign base = int'(cnt) * SLICE_W;
  assign sa   = SLICE_W'(a_q >> base);
  assign sb   = SLICE_W'(b_q >> base);

  fa_slice #(.W(SLICE_W)) u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .s    (ss),
    .cout (sc)
  );

  always_comb begin
    psum_nxt = (psum & ~(SMASK << base)) | (DATA_W'(ss) << base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_q   <= A;
          b_q   <= B;
          carry <= Cin;
          cnt   <= '0;
          psum  <= '0;
          busy  <= 1'b1;
          state <= ADD;
        end
        ADD: begin
          psum  <= psum_nxt;
          carry <= sc;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final carry goes to Cout only; it is never fed back into a slice.
            Sum   <= psum_nxt;
            Cout  <= sc;
            Z     <= (psum_nxt == '0);
            N     <= psum_nxt[DATA_W-1];
            V     <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                     (psum_nxt[DATA_W-1] != a_q[DATA_W-1]);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fa_32bit_multicycle.sv
// Self-checking bench: directed vector table, handshake corner cases and
// randomized operations checked against a plain-arithmetic reference.
module tb_fa_32bit_multicycle;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = 32 / SLICE_W;

  logic        clk = 1'b0;
  logic        rst, start, Cin;
  logic [31:0] A, B;
  logic        busy, done, Cout, Z, N, V;
  logic [31:0] Sum;

  int errors = 0;
  int checks = 0;

  fa_32bit_multicycle #(.SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] sum;
    logic        cout, z, n, v;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Runs one operation; returns cycles from the accepting cycle to done (inclusive).
  // Inputs are scrambled after capture so a design that re-reads them is caught.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; Cin = 1'($urandom);
    check("busy_after_accept", {32'd0, busy}, 33'd1);
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("done_seen", {32'd0, done}, 33'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] es, input logic ec,
                              input logic ez, input logic en, input logic ev);
    check({tag, "_sum"},  {1'b0, Sum}, {1'b0, es});
    check({tag, "_flags"}, {29'd0, Cout, Z, N, V}, {29'd0, ec, ez, en, ev});
  endtask

  initial begin
    int lat, nd, last_done;
    int dq[$];
    logic [32:0] full;
    logic [31:0] ra, rb;
    logic rc;

    vecs[0] = '{32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0101, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {Sum, 1'b0}, 33'd0);
    check("reset_status", {26'd0, busy, done, Cout, Z, N, V, 1'b0}, 33'd0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_latency", i), 33'(lat), 33'(NSLICE + 1));
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), {31'd0, done, busy}, 33'd0);
      check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].z,
                   vecs[i].n, vecs[i].v);
    end

    // start pulsed while busy is dropped
    @(negedge clk);
    A = 32'h5; B = 32'h3; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("drop_done_count", 33'(nd), 33'd1);
    check_result("drop", 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held: back-to-back operations spaced NSLICE+2 cycles
    @(negedge clk);
    A = 32'h1; B = 32'h1; Cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dq.push_back(i);
    end
    start = 1'b0;
    check("held_done_count_ge2", 33'(dq.size() >= 2), 33'd1);
    if (dq.size() >= 2) check("held_spacing", 33'(dq[1] - dq[0]), 33'(NSLICE + 2));
    repeat (8) @(negedge clk);
    check_result("held", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the second ADD cycle aborts with no done
    A = 32'h10; B = 32'h20; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {Sum, 1'b0}, 33'd0);
    check("abort_status", {26'd0, busy, done, Cout, Z, N, V, 1'b0}, 33'd0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 33'(nd), 33'd0);
    op(32'h10, 32'h20, 1'b0, lat);
    check("after_abort_latency", 33'(lat), 33'(NSLICE + 1));
    check_result("after_abort", 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operations against plain 33-bit arithmetic
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      op(ra, rb, rc, lat);
      check($sformatf("rnd%0d_latency", i), 33'(lat), 33'(NSLICE + 1));
      check_result($sformatf("rnd%0d", i), full[31:0], full[32], full[31:0] == 0,
                   full[31], (ra[31] == rb[31]) && (full[31] != ra[31]));
    end

    // Outputs hold between completions
    last_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) last_done++;
    end
    check("idle_no_done", 33'(last_done), 33'd0);
    check("hold_sum", {1'b0, Sum}, {1'b0, full[31:0]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
